// File: rtl/seven_seg_scan_ctrl_pkg.sv
// Shared display package: converter state encoding, display constants and segment patterns.
package seven_seg_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StLatch = 2'd2
    } conv_state_e;

    localparam int unsigned DIGITS     = 4;
    localparam int unsigned MAX_VALUE  = 9999;
    localparam logic [3:0]  BLANK_CODE = 4'hF;
    localparam int unsigned BIN_W      = 14;
    localparam int unsigned BCD_W      = 16;

    // Active-high segment patterns, bit 0 = segment a, bit 7 (dp) always off.
    localparam logic [7:0] SEG_0   = 8'h3F;
    localparam logic [7:0] SEG_1   = 8'h06;
    localparam logic [7:0] SEG_2   = 8'h5B;
    localparam logic [7:0] SEG_3   = 8'h4F;
    localparam logic [7:0] SEG_4   = 8'h66;
    localparam logic [7:0] SEG_5   = 8'h6D;
    localparam logic [7:0] SEG_6   = 8'h7D;
    localparam logic [7:0] SEG_7   = 8'h07;
    localparam logic [7:0] SEG_8   = 8'h7F;
    localparam logic [7:0] SEG_9   = 8'h6F;
    localparam logic [7:0] SEG_OFF = 8'h00;

    // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] res;
        res = bcd;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (res[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = res[4*i +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_seg_decoder.sv
// BCD to seven-segment decoder; codes 10-15 (including the blank code) light nothing.
module bcd_seg_decoder
    import seven_seg_scan_ctrl_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [7:0] o_seg
);

    // Pure lookup of the segment pattern for the current digit code.
    always_comb begin
        o_seg = SEG_OFF;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit multiplexed display: binary-to-BCD converter feeding a display register,
// plus a free-running digit scanner with optional leading-zero blanking.
module seven_seg_scan_ctrl
    import seven_seg_scan_ctrl_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BIN_W-1:0]  value_in,
    input  logic              value_valid,
    input  logic              lz_blank_en,
    output logic              busy,
    output logic [DIGITS-1:0] an,
    output logic [3:0]        digit_bcd,
    output logic [7:0]        seg
);

    localparam int unsigned         PRESC_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PRESC_W-1:0]  PRESC_MAX = PRESC_W'(REFRESH_DIV - 1);
    localparam logic [3:0]          ITER_LAST = 4'(BIN_W - 1);
    localparam logic [BIN_W-1:0]    CLAMP_VAL = BIN_W'(MAX_VALUE);

    conv_state_e        r_state;
    logic [BIN_W-1:0]   r_bin;
    logic [BCD_W-1:0]   r_bcd;
    logic [3:0]         r_iter;
    logic               r_pend_vld;
    logic [BIN_W-1:0]   r_pend_val;
    logic [BCD_W-1:0]   r_disp;
    logic               r_busy;

    logic [PRESC_W-1:0] r_presc;
    logic [1:0]         r_idx;
    logic [DIGITS-1:0]  r_an;

    logic [BIN_W-1:0]       w_clamped;
    logic                   w_start;
    logic [BIN_W-1:0]       w_start_val;
    logic [BCD_W-1:0]       w_adj;
    logic [BCD_W+BIN_W-1:0] w_shifted;
    logic [1:0]             w_idx_nxt;
    logic [3:0]             w_nib;
    logic                   w_blank;

    assign w_clamped = (value_in > CLAMP_VAL) ? CLAMP_VAL : value_in;
    assign w_adj     = dabble_adjust(r_bcd);
    assign w_shifted = {w_adj, r_bin} << 1;
    assign w_idx_nxt = r_idx + 2'd1;

    // A new conversion starts from IDLE (fresh strobe wins over a parked one) or
    // straight out of LATCH when a strobe was parked during the previous conversion.
    always_comb begin
        w_start     = 1'b0;
        w_start_val = r_pend_val;
        if (r_state == StIdle) begin
            w_start = value_valid || r_pend_vld;
            if (value_valid) begin
                w_start_val = w_clamped;
            end
        end else if (r_state == StLatch) begin
            w_start = r_pend_vld;
        end
    end

    // Converter FSM: capture, 14 shift-add iterations, then atomic display update.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StIdle;
            r_bin      <= '0;
            r_bcd      <= '0;
            r_iter     <= '0;
            r_pend_vld <= 1'b0;
            r_pend_val <= '0;
            r_disp     <= '0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    r_pend_vld <= 1'b0;
                    if (w_start) begin
                        r_bin   <= w_start_val;
                        r_bcd   <= '0;
                        r_iter  <= '0;
                        r_state <= StShift;
                        r_busy  <= 1'b1;
                    end
                end
                StShift: begin
                    r_bcd  <= w_shifted[BCD_W+BIN_W-1:BIN_W];
                    r_bin  <= w_shifted[BIN_W-1:0];
                    r_iter <= r_iter + 4'd1;
                    if (r_iter == ITER_LAST) begin
                        r_state <= StLatch;
                    end
                    if (value_valid) begin
                        r_pend_vld <= 1'b1;
                        r_pend_val <= w_clamped;
                    end
                end
                StLatch: begin
                    r_disp     <= r_bcd;
                    r_pend_vld <= value_valid;
                    if (value_valid) begin
                        r_pend_val <= w_clamped;
                    end
                    if (w_start) begin
                        r_bin   <= w_start_val;
                        r_bcd   <= '0;
                        r_iter  <= '0;
                        r_state <= StShift;
                    end else begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Scanner: prescaler advances the digit index; anode enables are registered alongside it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
            r_idx   <= '0;
            r_an    <= 4'b1110;
        end else if (r_presc == PRESC_MAX) begin
            r_presc <= '0;
            r_idx   <= w_idx_nxt;
            r_an    <= ~(4'b0001 << w_idx_nxt);
        end else begin
            r_presc <= r_presc + PRESC_W'(1);
        end
    end

    // Digit select with leading-zero blanking; digit 0 is never blanked.
    always_comb begin
        w_nib   = r_disp[3:0];
        w_blank = 1'b0;
        case (r_idx)
            2'd0: begin
                w_nib   = r_disp[3:0];
                w_blank = 1'b0;
            end
            2'd1: begin
                w_nib   = r_disp[7:4];
                w_blank = (r_disp[15:4] == 12'd0);
            end
            2'd2: begin
                w_nib   = r_disp[11:8];
                w_blank = (r_disp[15:8] == 8'd0);
            end
            default: begin
                w_nib   = r_disp[15:12];
                w_blank = (r_disp[15:12] == 4'd0);
            end
        endcase
        digit_bcd = (lz_blank_en && w_blank) ? BLANK_CODE : w_nib;
    end

    assign busy = r_busy;
    assign an   = r_an;

    bcd_seg_decoder u_seg_dec (
        .i_bcd (digit_bcd),
        .o_seg (seg)
    );

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench: per-cycle scan/digit/segment monitor fed by a scoreboard of
// expected display updates, a table of single conversions and hand-written corner cases.
module tb_seven_seg_scan_ctrl;

    localparam int unsigned REFRESH_DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [13:0] value_in = '0;
    logic        value_valid = 1'b0;
    logic        lz_blank_en = 1'b0;
    logic        busy;
    logic [3:0]  an;
    logic [3:0]  digit_bcd;
    logic [7:0]  seg;

    always #5 clk = ~clk;

    seven_seg_scan_ctrl #(
        .REFRESH_DIV (REFRESH_DIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .value_in    (value_in),
        .value_valid (value_valid),
        .lz_blank_en (lz_blank_en),
        .busy        (busy),
        .an          (an),
        .digit_bcd   (digit_bcd),
        .seg         (seg)
    );

    typedef struct {
        int unsigned due;
        logic [15:0] val;
    } exp_t;

    typedef struct {
        logic [13:0] value;
        logic        lz;
        logic [15:0] exp_bcd;
    } vec_t;

    exp_t        sb_q[$];
    int unsigned edge_cnt = 0;
    int unsigned scan_cnt = 0;
    int unsigned busy_run = 0;
    int unsigned n_vec = 0;
    int unsigned n_miss = 0;
    logic [15:0] exp_disp = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s at edge %0d: got %0h, want %0h", name, edge_cnt, act, exp);
        end
    endtask

    function automatic logic [7:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    return 8'h3F;
            4'd1:    return 8'h06;
            4'd2:    return 8'h5B;
            4'd3:    return 8'h4F;
            4'd4:    return 8'h66;
            4'd5:    return 8'h6D;
            4'd6:    return 8'h7D;
            4'd7:    return 8'h07;
            4'd8:    return 8'h7F;
            4'd9:    return 8'h6F;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [3:0] exp_digit(input logic [15:0] d, input int unsigned idx,
                                             input logic lz);
        logic blank;
        blank = lz && (idx > 0);
        for (int k = int'(idx); k < 4; k++) begin
            if (d[4*k +: 4] != 4'd0) blank = 1'b0;
        end
        return blank ? 4'hF : d[4*idx +: 4];
    endfunction

    // One clock: advance the model, retire due scoreboard entries, check scan outputs.
    task automatic tick();
        int unsigned idx;
        logic [3:0]  e_an;
        logic [3:0]  e_dig;
        logic [7:0]  e_seg;
        @(posedge clk);
        #1;
        edge_cnt++;
        if (rst) begin
            exp_disp = '0;
            sb_q.delete();
            scan_cnt = 0;
        end else begin
            scan_cnt++;
            if (sb_q.size() > 0 && sb_q[0].due == edge_cnt) begin
                exp_disp = sb_q[0].val;
                void'(sb_q.pop_front());
            end
        end
        busy_run = busy ? busy_run + 1 : 0;
        idx   = (scan_cnt / REFRESH_DIV) % 4;
        e_an  = ~(4'b0001 << idx);
        e_dig = exp_digit(exp_disp, idx, lz_blank_en);
        e_seg = seg_of(e_dig);
        check("an", 32'(an), 32'(e_an));
        check("digit_bcd", 32'(digit_bcd), 32'(e_dig));
        check("seg", 32'(seg), 32'(e_seg));
    endtask

    // Drive a one-cycle strobe; when expected to be displayed, schedule it 15 edges after sampling.
    task automatic strobe(input logic [13:0] v, input bit push, input logic [15:0] bcd);
        exp_t e;
        value_in    = v;
        value_valid = 1'b1;
        if (push) begin
            e.due = edge_cnt + 1 + 15;
            e.val = bcd;
            sb_q.push_back(e);
        end
        tick();
        value_valid = 1'b0;
    endtask

    vec_t vecs[10];

    initial begin
        int unsigned e0;
        exp_t        ex;

        vecs[0] = '{14'd2048,  1'b1, 16'h2048};
        vecs[1] = '{14'd12000, 1'b0, 16'h9999};
        vecs[2] = '{14'd7,     1'b1, 16'h0007};
        vecs[3] = '{14'd7,     1'b0, 16'h0007};
        vecs[4] = '{14'd0,     1'b1, 16'h0000};
        vecs[5] = '{14'd100,   1'b1, 16'h0100};
        vecs[6] = '{14'd16383, 1'b1, 16'h9999};
        vecs[7] = '{14'd9999,  1'b0, 16'h9999};
        vecs[8] = '{14'd1234,  1'b0, 16'h1234};
        vecs[9] = '{14'd5,     1'b1, 16'h0005};

        // Reset with a strobe held high: it must be ignored.
        rst         = 1'b1;
        value_in    = 14'd1234;
        value_valid = 1'b1;
        repeat (3) tick();
        check("busy_in_reset", 32'(busy), 32'd0);
        value_valid = 1'b0;
        rst         = 1'b0;

        // Idle scan with blanking: digit 0 shows 0, others blank.
        lz_blank_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("busy_idle", 32'(busy), 32'd0);
        end

        // Table of single conversions.
        for (int v = 0; v < 10; v++) begin
            lz_blank_en = vecs[v].lz;
            strobe(vecs[v].value, 1'b1, vecs[v].exp_bcd);
            repeat (14) tick();
            check("busy_len", busy_run, 32'd15);
            tick();
            check("busy_done", 32'(busy), 32'd0);
            repeat (16) tick();
        end

        // Overlapping strobes: 16, then 512 and 64 while busy; 512 is overwritten.
        lz_blank_en = 1'b0;
        strobe(14'd16, 1'b1, 16'h0016);
        e0 = edge_cnt;
        repeat (2) tick();
        strobe(14'd512, 1'b0, 16'h0000);
        tick();
        strobe(14'd64, 1'b0, 16'h0000);
        ex.due = e0 + 30;
        ex.val = 16'h0064;
        sb_q.push_back(ex);
        while (edge_cnt < e0 + 29) tick();
        check("busy_chain", busy_run, 32'd30);
        tick();
        check("busy_chain_done", 32'(busy), 32'd0);
        repeat (20) tick();

        // Reset mid-conversion aborts and discards.
        strobe(14'd4096, 1'b1, 16'h4096);
        e0 = edge_cnt;
        while (edge_cnt < e0 + 7) tick();
        rst = 1'b1;
        tick();
        check("busy_abort", 32'(busy), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 24; i++) begin
            tick();
            check("busy_after_abort", 32'(busy), 32'd0);
        end

        check("scoreboard_empty", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_ctrl.md
SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, clock cycles each digit is driven before the scan advances (minimum 2).
REQ-002 SHALL have port clk  input  1  system clock; all logic is on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port value_in  input  14  unsigned binary value to display.
REQ-005 SHALL have port value_valid  input  1  single-cycle strobe qualifying value_in.
REQ-006 SHALL have port lz_blank_en  input  1  enables leading-zero blanking when 1.
REQ-007 SHALL have port busy  output  1  high while a conversion is in progress.
REQ-008 SHALL have port an  output  4  digit enables, active-low and one-hot; bit 0 is the least-significant digit.
REQ-009 SHALL have port digit_bcd  output  4  BCD code for the digit currently enabled, with 4'hF meaning blank.
REQ-010 SHALL have port seg  output  8  segment pattern for digit_bcd, active-high, bit 0 = segment a.

Function
REQ-011 Converter FSM SHALL have three states: IDLE, SHIFT and LATCH.
REQ-012 In IDLE, value_valid=1 SHALL capture min(value_in, 9999) and move to SHIFT on the next cycle.
REQ-013 SHIFT SHALL perform one double-dabble iteration per cycle, adding 3 to any nibble >=5 and then shifting left by 1, for exactly 14 cycles before moving to LATCH.
REQ-014 LATCH SHALL write the 4 BCD nibbles to the display register in one cycle, then return to IDLE.
REQ-015 The display register SHALL update exactly 16 cycles after the cycle in which value_valid is sampled in IDLE.
REQ-016 busy SHALL be 1 in every SHIFT and LATCH cycle and 0 in IDLE.
REQ-017 value_valid sampled while busy SHALL be stored in a one-deep pending slot; a later strobe overwrites the slot (last value wins).
REQ-018 With the slot full, LATCH SHALL move to SHIFT instead of IDLE, start that conversion and clear the slot, with busy staying 1.
REQ-019 value_valid in the same cycle as LATCH SHALL be captured into the pending slot.
REQ-020 The display register SHALL change only in LATCH; the displayed digits SHALL never show a partial conversion.
REQ-021 The scan prescaler SHALL count 0 to REFRESH_DIV-1 and wrap to 0.
REQ-022 On prescaler wrap, the digit index SHALL advance 0->1->2->3->0.
REQ-023 an SHALL equal the active-low one-hot decode of the digit index and SHALL be registered, so it is never all-ones or multi-hot.
REQ-024 digit_bcd SHALL equal display nibble [index], or 4'hF when lz_blank_en=1, index>0 and all nibbles from index to 3 are zero.
REQ-025 Digit 0 SHALL never be blanked, so a value of 0 displays as a single "0".
REQ-026 seg SHALL be the combinational decode of digit_bcd: 0-9 give the standard patterns, 10-15 give all zeros, and bit 7 is always 0.
REQ-027 Scanning SHALL run continuously and independently of converter state.

Reset
REQ-028 While rst=1, the FSM SHALL be IDLE, pending slot empty, busy=0, display register 0, prescaler 0, index 0, an=4'b1110, digit_bcd=0 and seg=8'b00111111.
REQ-029 rst asserted mid-conversion SHALL abort it, discard the pending value and leave the display register at 0.
REQ-030 value_valid SHALL be ignored in any cycle with rst=1.

Structure
REQ-031 The state encoding, the constants DIGITS=4, MAX_VALUE=9999 and BLANK_CODE=4'hF, and the segment pattern constants SHALL live in a shared display package.
REQ-032 The seg decode SHALL be the sole sub-module, named bcd_seg_decoder.
REQ-033 Converter and scanner SHALL be inline processes in the top module.

Verification
REQ-034 Using REFRESH_DIV=4: after reset, the bench SHALL check an cycles 1110->1101->1011->0111->1110, each held 4 cycles; with lz_blank_en=1, digit 0 shows 0 and digits 1-3 show 4'hF.
REQ-035 value_in=2048 with one strobe SHALL give busy high for 15 cycles and display nibbles {2,0,4,8} at strobe+16; with lz_blank_en=1 no digit is blanked.
REQ-036 value_in=12000 SHALL be clamped and displayed as 9999.
REQ-037 Strobe 16 at cycle 0, then 512 at cycle 3 and 64 at cycle 5 while busy SHALL show 16, then 64; busy stays high continuously, and 512 is never displayed.
REQ-038 value_in=7 with lz_blank_en=1 SHALL give digit_bcd {F,F,F,7} and seg all-zero on digits 1-3; with lz_blank_en=0 it SHALL give {0,0,0,7}.
REQ-039 rst pulsed at cycle 8 of converting 4096 SHALL give display 0 and busy 0 the next cycle, with no later update.
